pe_sequencer: RTL and testbench

// - Control-side counterpart of the pe MAC element: drives act/wgt/store/reuse/addr/update_out
//   and collects the finished dot product from the PE's out port.
// - Loads stationary weights into PE regfile slots, streams activations, flushes, returns result.
// - Sits between the array scheduler and one pe instance; one sequencer per PE column/row.

---
 rtl/pe_sequencer.sv | 148 ++++++++++++++
 tb/tb_pe_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// Control sequencer for one PE: loads stationary weights, streams MAC elements, returns the sum.
// Optional perf counters: define PE_SEQ_PERF_EN.
module pe_sequencer #(
  parameter int IN_PRECISION  = 16,
  parameter int OUT_PRECISION = 32,
  parameter int REG_SIZE      = 4,
  parameter int LEN_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_valid,
  output logic                     wgt_ready,
  input  logic [IN_PRECISION-1:0]  wgt_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     cmd_reuse,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [IN_PRECISION-1:0]  act_data,
  input  logic [IN_PRECISION-1:0]  act_wgt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_PRECISION-1:0] res_data,
  output logic [IN_PRECISION-1:0]  pe_act,
  output logic [IN_PRECISION-1:0]  pe_wgt,
  output logic                     pe_store,
  output logic                     pe_reuse,
  output logic                     pe_update_out,
  output logic [REG_SIZE-1:0]      pe_addr,
  input  logic [OUT_PRECISION-1:0] pe_out
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_mac_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int PW = (REG_SIZE > 2) ? $clog2(REG_SIZE) : 1;
  localparam logic [PW-1:0] PTR_FIRST = PW'(1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(REG_SIZE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MAC     = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]       state;
  logic             live;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             reuse_q;
  logic             idle;
  logic             wgt_fire;
  logic             cmd_fire;
  logic             act_fire;

  // live keeps the ready outputs low while reset is held
  assign idle      = (state == S_IDLE) && live;
  assign cmd_ready = idle;
  assign wgt_ready = idle && !cmd_valid;
  assign act_ready = (state == S_MAC);
  assign res_valid = (state == S_HOLD);
  assign wgt_fire  = wgt_valid && wgt_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign act_fire  = act_valid && act_ready;

  always_comb begin
    pe_act        = '0;
    pe_wgt        = '0;
    pe_store      = 1'b0;
    pe_reuse      = 1'b0;
    pe_update_out = 1'b0;
    pe_addr       = '0;
    if (wgt_fire) begin
      pe_store = 1'b1;
      pe_addr  = REG_SIZE'(wr_ptr);
      pe_wgt   = wgt_data;
    end
    if (act_fire) begin
      pe_act   = act_data;
      pe_wgt   = act_wgt;
      pe_reuse = reuse_q;
      pe_addr  = reuse_q ? REG_SIZE'(rd_ptr) : '0;
    end
    if (state == S_FLUSH) pe_update_out = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      live     <= 1'b0;
      wr_ptr   <= PTR_FIRST;
      rd_ptr   <= PTR_FIRST;
      len_q    <= '0;
      cnt      <= '0;
      reuse_q  <= 1'b0;
      res_data <= '0;
    end else begin
      live <= 1'b1;
      if (wgt_fire)
        wr_ptr <= (wr_ptr == PTR_LAST) ? PTR_FIRST : wr_ptr + 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            len_q   <= cmd_len;
            reuse_q <= cmd_reuse;
            rd_ptr  <= PTR_FIRST;
            cnt     <= '0;
            state   <= (cmd_len == '0) ? S_FLUSH : S_MAC;
          end
        end
        S_MAC: begin
          if (act_fire) begin
            cnt    <= cnt + 1'b1;
            rd_ptr <= (rd_ptr == PTR_LAST) ? PTR_FIRST : rd_ptr + 1'b1;
            if (cnt == len_q - LEN_W'(1)) state <= S_FLUSH;
          end
        end
        S_FLUSH:   state <= S_CAPTURE;
        S_CAPTURE: begin
          res_data <= pe_out;
          state    <= S_HOLD;
        end
        S_HOLD:    if (res_ready) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mac_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (act_fire && perf_mac_cnt != '1)
        perf_mac_cnt <= perf_mac_cnt + 1'b1;
      if (state == S_MAC && !act_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer with a behavioural PE attached.
// Directed job table, a reset-mid-job sequence and randomized jobs vs a reference model.
module tb_pe_sequencer;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int RS = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wgt_valid = 1'b0;
  logic          wgt_ready;
  logic [IW-1:0] wgt_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_reuse = 1'b0;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic [IW-1:0] act_data = '0;
  logic [IW-1:0] act_wgt = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_data;
  logic [IW-1:0] pe_act;
  logic [IW-1:0] pe_wgt;
  logic          pe_store;
  logic          pe_reuse;
  logic          pe_update_out;
  logic [RS-1:0] pe_addr;
  logic [OW-1:0] pe_out;
`ifdef PE_SEQ_PERF_EN
  logic [31:0]   perf_mac_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  pe_sequencer #(
    .IN_PRECISION(IW), .OUT_PRECISION(OW), .REG_SIZE(RS), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_reuse(cmd_reuse),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data), .act_wgt(act_wgt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .pe_act(pe_act), .pe_wgt(pe_wgt), .pe_store(pe_store),
    .pe_reuse(pe_reuse), .pe_update_out(pe_update_out),
    .pe_addr(pe_addr), .pe_out(pe_out)
`ifdef PE_SEQ_PERF_EN
    , .perf_mac_cnt(perf_mac_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // behavioural PE: MACs every cycle, update_out moves acc to out and clears acc
  logic [IW-1:0] rf [RS];
  logic [OW-1:0] acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      pe_out <= '0;
      for (int i = 0; i < RS; i++) rf[i] <= '0;
    end else begin
      if (pe_store) rf[pe_addr[1:0]] <= pe_wgt;
      if (pe_update_out) begin
        pe_out <= acc;
        acc    <= '0;
      end else begin
        acc <= acc + OW'(pe_act) * OW'(pe_reuse ? rf[pe_addr[1:0]] : pe_wgt);
      end
    end
  end

  int    n_chk = 0;
  int    n_fail = 0;
  string cur_tag = "";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, nm, act, exp);
    end
  endtask

  // reference weight slots and write pointer
  logic [IW-1:0] rs_slot [4];
  int            rwp = 1;
  int            tot_mac = 0;
  int            tot_stall = 0;

  logic [IW-1:0] j_w [$];
  logic [IW-1:0] j_a [$];
  logic [IW-1:0] j_b [$];
  int            j_gap [$];
  int            j_len;
  bit            j_reuse;
  int            j_hold;

  function automatic logic [31:0] model_exp();
    logic [IW-1:0] s [4];
    logic [31:0]   sum;
    logic [IW-1:0] w;
    int            p;
    s = rs_slot;
    p = rwp;
    foreach (j_w[k]) begin
      s[p] = j_w[k];
      p = (p == 3) ? 1 : p + 1;
    end
    sum = 0;
    for (int i = 0; i < j_len; i++) begin
      w = j_reuse ? s[1 + i % 3] : j_b[i];
      sum = sum + 32'(j_a[i]) * 32'(w);
    end
    return sum;
  endfunction

  task automatic idle_inputs();
    wgt_valid = 1'b0;
    cmd_valid = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] exp);
    int n;
    int gaps;
    bit seen;
    foreach (j_w[k]) begin
      @(negedge clk);
      idle_inputs();
      wgt_valid = 1'b1;
      wgt_data = j_w[k];
      #1;
      chk("wgt_ready", wgt_ready, 1);
      chk("store", pe_store, 1);
      chk("store_addr", pe_addr, rwp);
      chk("store_wgt", pe_wgt, j_w[k]);
      @(posedge clk);
      rs_slot[rwp] = j_w[k];
      rwp = (rwp == 3) ? 1 : rwp + 1;
    end
    // weight offered together with the command must lose
    @(negedge clk);
    wgt_valid = 1'b1;
    wgt_data = 16'hdead;
    cmd_valid = 1'b1;
    cmd_len = LW'(j_len);
    cmd_reuse = j_reuse;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    chk("cmd_wins", pe_store, 0);
    @(posedge clk);
    n = 1;
    gaps = 0;
    for (int i = 0; i < j_len; i++) begin
      for (int g = 0; g < j_gap[i]; g++) begin
        @(negedge clk);
        idle_inputs();
        #1;
        chk("stall_ready", act_ready, 1);
        chk("stall_act", pe_act, 0);
        @(posedge clk);
        n++;
        gaps++;
      end
      @(negedge clk);
      idle_inputs();
      act_valid = 1'b1;
      act_data = j_a[i];
      act_wgt = j_b[i];
      #1;
      chk("mac_act", pe_act, j_a[i]);
      chk("mac_addr", pe_addr, j_reuse ? 1 + i % 3 : 0);
      chk("mac_reuse", pe_reuse, j_reuse);
      @(posedge clk);
      n++;
    end
    tot_mac += j_len;
    tot_stall += gaps;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (res_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("res_timeout", seen, 1);
    if (seen) begin
      chk("latency", n, j_len + 3 + gaps);
      chk("res_data", res_data, exp);
      for (int h = 0; h < j_hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, exp);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk("done_valid", res_valid, 0);
      chk("done_cmd_ready", cmd_ready, 1);
    end
  endtask

  typedef struct {
    int            nw;
    logic [IW-1:0] w [3];
    int            len;
    bit            reuse;
    logic [IW-1:0] a [5];
    logic [IW-1:0] b [5];
    int            gap [5];
    int            hold;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl [7];

  task automatic load_vec(input vec_t v);
    j_w.delete();
    j_a.delete();
    j_b.delete();
    j_gap.delete();
    for (int k = 0; k < v.nw; k++) j_w.push_back(v.w[k]);
    for (int k = 0; k < v.len; k++) begin
      j_a.push_back(v.a[k]);
      j_b.push_back(v.b[k]);
      j_gap.push_back(v.gap[k]);
    end
    j_len = v.len;
    j_reuse = v.reuse;
    j_hold = v.hold;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            nw;
    logic [31:0]   e;
    tbl[0] = '{3, '{16'd3, 16'd5, 16'd7}, 3, 1'b1,
               '{16'd2, 16'd4, 16'd6, 16'd0, 16'd0}, '{5{16'd0}}, '{5{0}}, 0, 32'd68};
    tbl[1] = '{0, '{3{16'd0}}, 5, 1'b1,
               '{5{16'd1}}, '{5{16'd0}}, '{5{0}}, 0, 32'd23};
    tbl[2] = '{0, '{3{16'd0}}, 2, 1'b0,
               '{16'd2, 16'd3, 16'd0, 16'd0, 16'd0},
               '{16'd10, 16'd100, 16'd0, 16'd0, 16'd0}, '{0, 4, 0, 0, 0}, 0, 32'd320};
    tbl[3] = '{0, '{3{16'd0}}, 0, 1'b1,
               '{5{16'd0}}, '{5{16'd0}}, '{5{0}}, 0, 32'd0};
    tbl[4] = '{0, '{3{16'd0}}, 2, 1'b1,
               '{16'd10, 16'd10, 16'd0, 16'd0, 16'd0}, '{5{16'd0}}, '{5{0}}, 5, 32'd80};
    tbl[5] = '{1, '{16'd9, 16'd0, 16'd0}, 3, 1'b1,
               '{5{16'd1}}, '{5{16'd0}}, '{5{0}}, 0, 32'd21};
    tbl[6] = '{0, '{3{16'd0}}, 2, 1'b0,
               '{5{16'hffff}}, '{5{16'hffff}}, '{5{0}}, 0, 32'hfffc0002};
    for (int i = 0; i < 4; i++) rs_slot[i] = '0;

    cur_tag = "reset";
    act_valid = 1'b1;
    #1;
    chk("cmd_ready", cmd_ready, 0);
    chk("wgt_ready", wgt_ready, 0);
    chk("act_ready", act_ready, 0);
    chk("res_valid", res_valid, 0);
    chk("res_data", res_data, 0);
    chk("pe_act", pe_act, 0);
    chk("pe_addr", pe_addr, 0);
    chk("pe_update", pe_update_out, 0);
    act_valid = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_wgt_ready", wgt_ready, 1);

    for (int v = 0; v < 7; v++) begin
      cur_tag = $sformatf("vec%0d", v);
      load_vec(tbl[v]);
      run_job(tbl[v].exp);
    end

    // reset in the middle of a job
    cur_tag = "midreset";
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len = 8'd4;
    cmd_reuse = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_inputs();
      act_valid = 1'b1;
      act_data = 16'd5;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("act_ready", act_ready, 0);
    chk("pe_act", pe_act, 0);
    chk("pe_addr", pe_addr, 0);
    chk("pe_reuse", pe_reuse, 0);
    chk("res_valid", res_valid, 0);
    chk("cmd_ready", cmd_ready, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rs_slot[i] = '0;
    rwp = 1;
    tot_mac = 0;
    tot_stall = 0;
    @(posedge clk);
    j_w = '{16'd2, 16'd3, 16'd4};
    j_a = '{16'd1, 16'd2, 16'd3};
    j_b = '{16'd0, 16'd0, 16'd0};
    j_gap = '{0, 0, 0};
    j_len = 3;
    j_reuse = 1'b1;
    j_hold = 0;
    run_job(32'd20);

    for (int r = 0; r < 15; r++) begin
      cur_tag = $sformatf("rand%0d", r);
      j_w.delete();
      j_a.delete();
      j_b.delete();
      j_gap.delete();
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) j_w.push_back(IW'($urandom));
      j_len = $urandom_range(0, 8);
      j_reuse = 1'($urandom_range(0, 1));
      j_hold = $urandom_range(0, 3);
      for (int k = 0; k < j_len; k++) begin
        j_a.push_back(IW'($urandom));
        j_b.push_back(IW'($urandom));
        j_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      e = model_exp();
      run_job(e);
    end

`ifdef PE_SEQ_PERF_EN
    cur_tag = "perf";
    chk("mac_cnt", perf_mac_cnt, tot_mac);
    chk("stall_cnt", perf_stall_cnt, tot_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
